// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program sequencer.
//   seq_state_t   : fetch FSM state (RUN fetches normally, HOLD stalls fetch)
//   DEF_ADDR_W    : default program memory address width
//   DEF_CNT_W     : default taken-branch counter width
//   JMP_NIBBLE_W  : number of jump-target bits supplied by the decoder;
//                   they form the top bits of the target, lower bits are zero
package program_sequencer_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } seq_state_t;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_CNT_W    = 8;
    localparam int JMP_NIBBLE_W = 4;

endpackage : program_sequencer_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk        : rising-edge clock
//   sync_reset : synchronous active-high reset, clears count
//   inc        : count up by one on this edge (ignored once all-ones)
//   count      : current count value
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule : sat_counter

// File: rtl/program_sequencer.sv
// Program sequencer: selects the next program memory address and keeps the
// program counter, with a fetch-stall FSM, a saturating taken-jump counter
// and a sticky pc-wrap flag.
//   clk          : rising-edge clock
//   sync_reset   : synchronous active-high reset (wins over all inputs)
//   jmp          : unconditional jump request (priority over jmp_nz)
//   jmp_nz       : jump-if-not-zero request
//   jmp_addr     : jump target nibble, target = {jmp_addr, zeros}
//   dont_jmp     : ALU zero flag, suppresses jmp_nz
//   hold         : fetch stall; pc frozen and jump requests discarded
//   pm_addr      : combinational next program memory address
//   pc           : registered program counter (loads pm_addr every edge)
//   branch_count : saturating count of taken jumps
//   wrapped      : sticky, set when pc increments from all-ones to zero
//   from_PS      : debug bus, constant zero
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    sync_reset,
    input  logic                    jmp,
    input  logic                    jmp_nz,
    input  logic [JMP_NIBBLE_W-1:0] jmp_addr,
    input  logic                    dont_jmp,
    input  logic                    hold,
    output logic [ADDR_W-1:0]       pm_addr,
    output logic [ADDR_W-1:0]       pc,
    output logic [CNT_W-1:0]        branch_count,
    output logic                    wrapped,
    output logic [7:0]              from_PS
);

    seq_state_t        state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic              wrapped_reg;

    logic [ADDR_W-1:0] pm_addr_next;
    logic [ADDR_W-1:0] jump_target;
    logic              jump_taken;
    logic              inc_wrap;

    assign jump_target = {jmp_addr, {(ADDR_W-JMP_NIBBLE_W){1'b0}}};

    // Next-address selection. hold always freezes the address at pc; once
    // hold drops, both RUN and the resuming HOLD cycle evaluate the decoder
    // requests, so a jump re-presented by the refetched instruction is taken
    // on the very first unstalled cycle.
    always_comb begin
        pm_addr_next = pc_reg;
        jump_taken   = 1'b0;
        inc_wrap     = 1'b0;
        if (sync_reset) begin
            pm_addr_next = '0;
        end else if (!hold) begin
            unique case (state_reg)
                RUN, HOLD: begin
                    if (jmp || (jmp_nz && !dont_jmp)) begin
                        pm_addr_next = jump_target;
                        jump_taken   = 1'b1;
                    end else begin
                        pm_addr_next = pc_reg + ADDR_W'(1);
                        // Only an increment past all-ones counts as a wrap,
                        // never a jump that happens to land on zero.
                        inc_wrap     = (pc_reg == '1);
                    end
                end
                default: pm_addr_next = pc_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_reg   <= RUN;
            pc_reg      <= '0;
            wrapped_reg <= 1'b0;
        end else begin
            state_reg <= hold ? HOLD : RUN;
            pc_reg    <= pm_addr_next;
            if (inc_wrap) begin
                wrapped_reg <= 1'b1;
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_branch_counter (
        .clk        (clk),
        .sync_reset (sync_reset),
        .inc        (jump_taken),
        .count      (branch_count)
    );

    assign pm_addr = pm_addr_next;
    assign pc      = pc_reg;
    assign wrapped = wrapped_reg;
    assign from_PS = 8'h00;

endmodule : program_sequencer

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: directed vectors followed by
// random stimulus, checked against a behavioural model of the sequencer.
// Two instances run in lockstep: default widths, and CNT_W=2 to exercise
// counter saturation.
module tb_program_sequencer;

    logic       clk;
    logic       sync_reset;
    logic       jmp;
    logic       jmp_nz;
    logic [3:0] jmp_addr;
    logic       dont_jmp;
    logic       hold;

    logic [7:0] pm_addr_a, pc_a, count_a, from_ps_a;
    logic       wrapped_a;
    logic [7:0] pm_addr_b, pc_b, from_ps_b;
    logic [1:0] count_b;
    logic       wrapped_b;

    int n_assert = 0;
    int n_fail   = 0;
    int n_step   = 0;

    // Behavioural model state
    int m_pc    = 0;
    int m_cnt8  = 0;
    int m_cnt2  = 0;
    int m_wrap  = 0;

    program_sequencer dut_a (
        .clk          (clk),
        .sync_reset   (sync_reset),
        .jmp          (jmp),
        .jmp_nz       (jmp_nz),
        .jmp_addr     (jmp_addr),
        .dont_jmp     (dont_jmp),
        .hold         (hold),
        .pm_addr      (pm_addr_a),
        .pc           (pc_a),
        .branch_count (count_a),
        .wrapped      (wrapped_a),
        .from_PS      (from_ps_a)
    );

    program_sequencer #(.CNT_W(2)) dut_b (
        .clk          (clk),
        .sync_reset   (sync_reset),
        .jmp          (jmp),
        .jmp_nz       (jmp_nz),
        .jmp_addr     (jmp_addr),
        .dont_jmp     (dont_jmp),
        .hold         (hold),
        .pm_addr      (pm_addr_b),
        .pc           (pc_b),
        .branch_count (count_b),
        .wrapped      (wrapped_b),
        .from_PS      (from_ps_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive, check the combinational address, clock,
    // then check the registered state against the model.
    task automatic step(input logic r, input logic j, input logic jnz,
                        input logic [3:0] a, input logic dj, input logic h);
        int exp_pm;
        int taken;
        sync_reset = r;
        jmp        = j;
        jmp_nz     = jnz;
        jmp_addr   = a;
        dont_jmp   = dj;
        hold       = h;
        taken      = 0;
        if (r)                    exp_pm = 0;
        else if (h)               exp_pm = m_pc;
        else if (j || (jnz && !dj)) begin
            exp_pm = a * 16;
            taken  = 1;
        end else                  exp_pm = (m_pc + 1) % 256;
        #1;
        check("pm_addr_a", 32'(pm_addr_a), 32'(exp_pm));
        check("pm_addr_b", 32'(pm_addr_b), 32'(exp_pm));
        @(posedge clk);
        #1;
        if (r) begin
            m_pc = 0; m_cnt8 = 0; m_cnt2 = 0; m_wrap = 0;
        end else if (!h) begin
            if (taken != 0) begin
                m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
                m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            end else if (m_pc == 255) begin
                m_wrap = 1;
            end
            m_pc = exp_pm;
        end
        check("pc_a", 32'(pc_a), 32'(m_pc));
        check("pc_b", 32'(pc_b), 32'(m_pc));
        check("count_a", 32'(count_a), 32'(m_cnt8));
        check("count_b", 32'(count_b), 32'(m_cnt2));
        check("wrapped_a", 32'(wrapped_a), 32'(m_wrap));
        check("wrapped_b", 32'(wrapped_b), 32'(m_wrap));
        check("from_PS", 32'({from_ps_a, from_ps_b}), 32'(0));
        $display("step %0d rst=%0b jmp=%0b jnz=%0b addr=%0h dz=%0b hold=%0b pm=%02h pc=%02h cnt=%0d/%0d wrap=%0b",
                 n_step, r, j, jnz, a, dj, h, pm_addr_a, pc_a, count_a, count_b, wrapped_a);
        n_step++;
    endtask

    initial begin
        sync_reset = 1'b1;
        jmp = 1'b0; jmp_nz = 1'b0; jmp_addr = 4'h0; dont_jmp = 1'b0; hold = 1'b0;

        // Reset two cycles (with a jump presented, which must not count),
        // then free-run: pm_addr 0,0,1,2,3,4,5.
        step(1, 1, 0, 4'h9, 0, 0);
        step(1, 0, 0, 4'h0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 4'h0, 0, 0);
        check("pc_after_run", 32'(pc_a), 32'h05);
        check("count_after_run", 32'(count_a), 32'h0);

        // Reach pc=12, then unconditional jump to A0.
        step(0, 1, 0, 4'h1, 0, 0);
        step(0, 0, 0, 4'h0, 0, 0);
        step(0, 0, 0, 4'h0, 0, 0);
        check("pc_at_12", 32'(pc_a), 32'h12);
        step(0, 1, 1, 4'hA, 0, 0);
        check("jmp_to_A0", 32'(pc_a), 32'hA0);

        // jmp_nz suppressed by zero flag, then taken.
        step(0, 1, 0, 4'h3, 0, 0);
        step(0, 0, 1, 4'h5, 1, 0);
        check("jnz_suppressed", 32'(pc_a), 32'h31);
        step(0, 1, 0, 4'h3, 0, 0);
        step(0, 0, 1, 4'h5, 0, 0);
        check("jnz_taken", 32'(pc_a), 32'h50);

        // Hold for three cycles with a jump pending, then resume with jump.
        step(0, 1, 0, 4'h4, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 4'hE, 0, 1);
        check("pc_held", 32'(pc_a), 32'h40);
        step(0, 1, 0, 4'h2, 0, 0);
        check("resume_jump", 32'(pc_a), 32'h20);

        // Jump target equal to pc+1 still counts (pc=1F -> 20).
        step(0, 1, 0, 4'h1, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 0, 0, 4'h0, 0, 0);
        step(0, 1, 0, 4'h2, 0, 0);

        // Reset, then jump to 0 from 7F must not set wrapped.
        step(1, 0, 0, 4'h0, 0, 0);
        step(0, 1, 0, 4'h7, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 0, 0, 4'h0, 0, 0);
        step(0, 1, 0, 4'h0, 0, 0);
        check("no_wrap_on_jump", 32'(wrapped_a), 32'h0);

        // Increment past FF sets wrapped, which stays set.
        step(0, 1, 0, 4'hF, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 4'h0, 0, 0);
        check("wrap_set", 32'(wrapped_a), 32'h1);
        step(0, 1, 0, 4'h3, 0, 0);
        check("wrap_sticky", 32'(wrapped_a), 32'h1);

        // Narrow counter saturation: 1,2,3,3,3.
        step(1, 0, 0, 4'h0, 0, 0);
        step(0, 1, 0, 4'h1, 0, 0); check("sat1", 32'(count_b), 32'h1);
        step(0, 0, 1, 4'h2, 0, 0); check("sat2", 32'(count_b), 32'h2);
        step(0, 1, 0, 4'h3, 0, 0); check("sat3", 32'(count_b), 32'h3);
        step(0, 1, 0, 4'h4, 0, 0); check("sat4", 32'(count_b), 32'h3);
        step(0, 1, 0, 4'h5, 0, 0); check("sat5", 32'(count_b), 32'h3);

        // Reset during a jump, and during hold, wins.
        step(1, 1, 0, 4'hC, 0, 0);
        check("rst_mid_jump_pc", 32'(pc_a), 32'h0);
        check("rst_mid_jump_cnt", 32'(count_b), 32'h0);
        step(0, 0, 0, 4'h0, 0, 0);
        step(0, 0, 0, 4'h0, 0, 1);
        step(1, 1, 1, 4'h6, 0, 1);
        check("rst_mid_hold_pc", 32'(pc_a), 32'h0);

        // Random stimulus against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) == 0,
                 4'($urandom_range(0, 15)),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 4) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_program_sequencer

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, program memory address width; jump targets are {jmp_addr, (ADDR_W-4) zeros}.
REQ-002 The block SHALL have parameter CNT_W, default 8, width of the taken-branch counter.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high: clk  in  1  rising-edge clock.
REQ-004 The block SHALL have port sync_reset  in  1  synchronous active-high reset.
REQ-005 The block SHALL have port jmp  in  1  unconditional jump request from the decoder, same cycle.
REQ-006 The block SHALL have port jmp_nz  in  1  jump-if-not-zero request from the decoder.
REQ-007 The block SHALL have port jmp_addr  in  4  jump target nibble (decoder ir_nibble).
REQ-008 The block SHALL have port dont_jmp  in  1  ALU zero flag; 1 suppresses jmp_nz.
REQ-009 The block SHALL have port hold  in  1  fetch stall request from the memory side.
REQ-010 The block SHALL have port pm_addr  out  ADDR_W  combinational next program memory address.
REQ-011 The block SHALL have port pc  out  ADDR_W  registered current program counter.
REQ-012 The block SHALL have port branch_count  out  CNT_W  saturating count of taken jumps.
REQ-013 The block SHALL have port wrapped  out  1  sticky flag: pc has wrapped from all-ones to zero.
REQ-014 The block SHALL have port from_PS  out  8  debug bus, driven to 8'h00.

Function
REQ-015 pm_addr SHALL be 0 while sync_reset=1, regardless of other inputs.
REQ-016 In state RUN with hold=0, pm_addr SHALL be the target if jmp=1, else the target if jmp_nz=1 and dont_jmp=0, else pc+1 modulo 2^ADDR_W.
REQ-017 jmp SHALL take priority over jmp_nz when both are asserted; one jump is counted.
REQ-018 pc SHALL load pm_addr on every rising edge of clk; latency from request to pc update is one cycle.
REQ-019 The FSM SHALL have states RUN and HOLD; RUN->HOLD when hold=1; HOLD->RUN when hold=0; sync_reset forces RUN.
REQ-020 While hold=1 (either state), pm_addr SHALL equal pc, jump requests SHALL be discarded and not counted, and pc SHALL be unchanged.
REQ-021 The first cycle in RUN after HOLD SHALL evaluate jmp/jmp_nz normally; the refetched instruction re-presents any discarded jump.
REQ-022 branch_count SHALL increment by 1 on each clock edge where a jump is taken per REQ-016, and SHALL saturate at all-ones.
REQ-023 wrapped SHALL set on the edge where pc transitions from all-ones to 0 by increment (not by jump target 0), and SHALL stay set until reset.
REQ-024 A jump whose target equals pc+1 SHALL still count as taken.
REQ-025 from_PS SHALL be 8'h00 at all times.

Reset
REQ-026 On an edge with sync_reset=1: pc=0, state=RUN, branch_count=0, wrapped=0; the reset cycle's jumps SHALL not count.
REQ-027 Reset asserted mid-hold or mid-jump SHALL win over every other input on that edge.
REQ-028 After reset release, the first fetched address SHALL be pm_addr=1 (pc=0 already fetched via pm_addr=0 during reset).

Structure
REQ-029 Package program_sequencer_pkg SHALL hold the FSM state type (RUN, HOLD), ADDR_W and CNT_W defaults, and the target-forming constant (4 jump-nibble bits).
REQ-030 The saturating counter SHALL be one sub-module, sat_counter, parameterised by width, with inputs clk, sync_reset, inc and output count.
REQ-031 All pm_addr selection SHALL be a single combinational process; pc, state, wrapped are registered.

Verification
REQ-032 Reset 2 cycles, release, run 5 cycles -> pm_addr 0,0,1,2,3,4,5; pc follows one cycle later; branch_count=0.
REQ-033 pc=8'h12, jmp=1, jmp_addr=4'hA -> pm_addr=8'hA0, next pc=8'hA0, branch_count=1.
REQ-034 pc=8'h30, jmp_nz=1, jmp_addr=4'h5: dont_jmp=1 -> pm_addr=8'h31, count unchanged; dont_jmp=0 -> pm_addr=8'h50, count+1.
REQ-035 pc=8'h40, hold=1 for 3 cycles with jmp=1 -> pm_addr=8'h40, pc=8'h40 throughout, count unchanged; hold=0 with jmp=1, jmp_addr=4'h2 -> pc=8'h20.
REQ-036 pc=8'hFF, no jump -> pc=8'h00, wrapped=1 and stays 1; jump to 4'h0 from 8'h7F -> wrapped unchanged.
REQ-037 CNT_W=2, 5 taken jumps -> branch_count 1,2,3,3,3; then sync_reset=1 during jmp=1 -> pc=0, count=0.
